// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU and its iterative multiplier.
//   - OP_ADD..OP_SHL : 3-bit opcodes presented on Sel
//   - state_t        : controller state encoding (ST_IDLE, ST_MUL, ST_DONE)
//   - result_width() : width of the result bus for a given operand width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The result bus is twice the operand width so that ADD carry, MUL and
    // SHL never lose bits.
    function automatic int result_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned shift-add multiplier, one multiplier bit per clock,
// LSB first. A Start pulse loads the operands and clears the accumulator and
// bit counter; Width clock edges later the product is complete.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-low reset
//   Start    in   load Mcand/Mplier and begin a new multiplication
//   Mcand    in   [Width-1:0]   multiplicand, unsigned
//   Mplier   in   [Width-1:0]   multiplier, unsigned
//   Done     out  high during the cycle whose rising edge retires the last bit
//   Product  out  [2*Width-1:0] accumulator value after the current step;
//                 equals Mcand*Mplier whenever Done is high
//
// Done and Product are combinational so the owner can capture the finished
// product on the same edge that processes the final bit, giving a total
// latency of Width edges after Start.
// -----------------------------------------------------------------------------
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                Start,
    input  logic [Width-1:0]                    Mcand,
    input  logic [Width-1:0]                    Mplier,
    output logic                                Done,
    output logic [result_width(Width)-1:0]      Product
);

    localparam int RW = result_width(Width);
    localparam int CW = $clog2(Width);

    logic [RW-1:0]    mcand_q;   // multiplicand, shifted left once per step
    logic [Width-1:0] mplier_q;  // multiplier, shifted right once per step
    logic [RW-1:0]    acc_q;     // partial product
    logic [CW-1:0]    cnt_q;     // index of the bit being examined
    logic             busy_q;

    logic [RW-1:0]    addend;
    logic [RW-1:0]    acc_next;

    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign acc_next = acc_q + addend;

    assign Done    = busy_q && (cnt_q == CW'(Width - 1));
    assign Product = acc_next;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (Start) begin
            mcand_q  <= {{Width{1'b0}}, Mcand};
            mplier_q <= Mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values of the others, as real flip-flops do.
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // Width is a power of two, so the counter wraps back to zero on
            // the final step without extra logic.
            cnt_q    <= cnt_q + CW'(1);
            if (Done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered ALU with valid/ready handshakes on both sides and one operation
// in flight. Seven ops complete in one cycle; MUL runs through the iterative
// shift_add_mul and completes Width cycles after its accept edge.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-low reset
//   In_Valid   in   request valid
//   In_Ready   out  request can be accepted (IDLE and not in reset)
//   A, B       in   [Width-1:0] unsigned operands
//   Sel        in   [2:0] opcode (see alu_pkg)
//   Out_Valid  out  result valid, held until Out_Ready
//   Out_Ready  in   consumer takes the result
//   Out        out  [2*Width-1:0] result
//   Zero       out  Out == 0, meaningful only with Out_Valid
//
// Width must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                In_Valid,
    output logic                                In_Ready,
    input  logic [Width-1:0]                    A,
    input  logic [Width-1:0]                    B,
    input  logic [2:0]                          Sel,
    output logic                                Out_Valid,
    input  logic                                Out_Ready,
    output logic [result_width(Width)-1:0]      Out,
    output logic                                Zero
);

    localparam int RW = result_width(Width);
    localparam int SW = $clog2(Width);

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] out_q;
    logic          zero_q;

    logic          accept;
    logic          load_single;
    logic          load_mul;
    logic [RW-1:0] single_res;

    logic          mul_start;
    logic          mul_done;
    logic [RW-1:0] mul_product;

    // -------------------------------------------------------------------------
    // Single-cycle operations. Operands are zero-extended to the result width
    // first, so ADD carries into bit Width and SUB wraps to a full-width
    // two's complement value. MUL never reaches this path.
    // -------------------------------------------------------------------------
    function automatic logic [RW-1:0] single_op(
        input logic [2:0]       op,
        input logic [Width-1:0] a,
        input logic [Width-1:0] b
    );
        logic [RW-1:0] a_ext;
        logic [RW-1:0] b_ext;
        a_ext = {{Width{1'b0}}, a};
        b_ext = {{Width{1'b0}}, b};
        case (op)
            OP_ADD:  return a_ext + b_ext;
            OP_SUB:  return a_ext - b_ext;
            OP_AND:  return a_ext & b_ext;
            OP_OR:   return a_ext | b_ext;
            OP_XOR:  return a_ext ^ b_ext;
            OP_INC:  return a_ext + RW'(1);
            // Shift amount is B mod Width; bits move into the upper half.
            OP_SHL:  return a_ext << b[SW-1:0];
            default: return '0;
        endcase
    endfunction

    assign single_res = single_op(Sel, A, B);

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // In_Ready is gated by RST so that no request looks accepted on an edge
    // where reset wins.
    assign In_Ready  = RST && (state_q == ST_IDLE);
    assign accept    = In_Valid && In_Ready;
    assign Out_Valid = (state_q == ST_DONE);
    assign Out       = out_q;
    assign Zero      = zero_q;

    assign mul_start = accept && (Sel == OP_MUL);

    shift_add_mul #(
        .Width (Width)
    ) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (mul_start),
        .Mcand   (A),
        .Mplier  (B),
        .Done    (mul_done),
        .Product (mul_product)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        load_single = 1'b0;
        load_mul    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (Sel == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d     = ST_DONE;
                        load_single = 1'b1;
                    end
                end
            end

            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    load_mul = 1'b1;
                end
            end

            ST_DONE: begin
                // Returning to IDLE here, rather than accepting directly,
                // keeps In_Ready purely a function of state.
                if (Out_Ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and result registers. Reset overrides everything, including an
    // in-flight multiply or an unconsumed result.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_single) begin
                out_q  <= single_res;
                zero_q <= (single_res == '0);
            end else if (load_mul) begin
                out_q  <= mul_product;
                zero_q <= (mul_product == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (Width = 8). Expected results are computed
// by an independent integer model, pushed to a queue when a request is
// driven and popped when the DUT presents the result. Inputs change shortly
// after rising edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic           CLK;
    logic           RST;
    logic           In_Valid;
    logic           In_Ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2:0]     Sel;
    logic           Out_Valid;
    logic           Out_Ready;
    logic [2*W-1:0] Out;
    logic           Zero;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    seq_alu #(
        .Width (W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out       (Out),
        .Zero      (Zero)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model on plain integers, reduced mod 2^16.
    function automatic logic [15:0] model(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b + 65536;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a * b;
            3'd6:    r = a + 1;
            default: r = a * (1 << (b % 8));
        endcase
        return r[15:0];
    endfunction

    // Pops the oldest expected result; an empty queue yields X so the
    // following comparison cannot pass.
    task automatic pop_expected(output logic [15:0] e);
        if (exp_q.size() == 0) e = 16'hxxxx;
        else e = exp_q.pop_front();
    endtask

    // Drives one request starting at a falling edge, holds it across the
    // accepting rising edge, then scrambles the inputs.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        @(negedge CLK);
        while (!In_Ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (!In_Ready) begin
            vectors++; miscompares++;
            $display("FAIL issue_ready: In_Ready=%b after %0d cycles, required 1", In_Ready, waited);
        end
        In_Valid = 1'b1; A = a; B = b; Sel = op;
        exp_q.push_back(model(op, int'(a), int'(b)));
        @(posedge CLK);
        #1;
        In_Valid = 1'b0; A = '0; B = '0; Sel = OP_ADD;
    endtask

    // Counts falling edges after the accept until Out_Valid; -1 on timeout.
    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge CLK);
            if (Out_Valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        A = '0; B = '0; Sel = OP_ADD;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", Out_Valid); end
        vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b expected 0", In_Ready); end
        vectors++; if (Out !== 16'h0000) begin miscompares++; $display("FAIL reset_out: got %h expected 0000", Out); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero: got %b expected 0", Zero); end
        RST = 1'b1;
        #1;
        vectors++; if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_high: got %b expected 1", In_Ready); end
    endtask

    task automatic test_add();
        logic [15:0] e;
        Out_Ready = 1'b1;
        issue(OP_ADD, 8'd200, 8'd100);
        @(negedge CLK);
        pop_expected(e);
        vectors++; if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: Out_Valid=%b expected 1", Out_Valid); end
        vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL add_ready_busy: got %b expected 0", In_Ready); end
        vectors++; if (Out !== e) begin miscompares++; $display("FAIL add_out: got %h expected %h", Out, e); end
        vectors++; if (Out !== 16'h012C) begin miscompares++; $display("FAIL add_carry: got %h expected 012c", Out); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b expected 0", Zero); end
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL add_handoff: Out_Valid=%b expected 0", Out_Valid); end
        vectors++; if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL add_ready_back: got %b expected 1", In_Ready); end
    endtask

    task automatic test_sub();
        logic [7:0]  av[2] = '{8'd3, 8'd5};
        logic [7:0]  bv[2] = '{8'd5, 8'd5};
        logic        zv[2] = '{1'b0, 1'b1};
        logic [15:0] e;
        int          cyc;
        Out_Ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(OP_SUB, av[i], bv[i]);
            wait_valid(5, cyc);
            pop_expected(e);
            vectors++; if (cyc != 1) begin miscompares++; $display("FAIL sub_latency[%0d]: got %0d cycles expected 1", i, cyc); end
            vectors++; if (Out !== e) begin miscompares++; $display("FAIL sub_out[%0d]: got %h expected %h", i, Out, e); end
            vectors++; if (Zero !== zv[i]) begin miscompares++; $display("FAIL sub_zero[%0d]: got %b expected %b", i, Zero, zv[i]); end
        end
    endtask

    task automatic test_mul();
        logic [15:0] e;
        Out_Ready = 1'b1;
        issue(OP_MUL, 8'd255, 8'd255);
        // A competing request is presented while busy; it must be ignored.
        In_Valid = 1'b1; A = 8'd3; B = 8'd3; Sel = OP_ADD;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL mul_ready_busy[c%0d]: got %b expected 0", k, In_Ready); end
            vectors++; if (Out_Valid !== (k == 9)) begin miscompares++; $display("FAIL mul_valid[c%0d]: got %b expected %b", k, Out_Valid, (k == 9)); end
            if (k == 9) begin
                In_Valid = 1'b0;
                pop_expected(e);
                vectors++; if (Out !== e) begin miscompares++; $display("FAIL mul_out: got %h expected %h", Out, e); end
                vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL mul_zero: got %b expected 0", Zero); end
            end
        end
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin miscompares++; $display("FAIL mul_release: valid=%b ready=%b expected 0/1", Out_Valid, In_Ready); end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        Out_Ready = 1'b0;
        issue(OP_AND, 8'h3D, 8'h17);
        pop_expected(e);
        In_Valid = 1'b1; A = 8'd1; B = 8'd1; Sel = OP_ADD;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            vectors++; if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[c%0d]: got %b expected 1", k, Out_Valid); end
            vectors++; if (Out !== e) begin miscompares++; $display("FAIL bp_out[c%0d]: got %h expected %h", k, Out, e); end
            vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[c%0d]: got %b expected 0", k, In_Ready); end
        end
        Out_Ready = 1'b1;
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle: valid=%b ready=%b expected 0/1", Out_Valid, In_Ready); end
        exp_q.push_back(model(OP_ADD, 1, 1));
        @(negedge CLK);
        In_Valid = 1'b0;
        pop_expected(e);
        vectors++; if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid: got %b expected 1", Out_Valid); end
        vectors++; if (Out !== e) begin miscompares++; $display("FAIL bp_next_out: got %h expected %h", Out, e); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        Out_Ready = 1'b1;
        @(negedge CLK);
        In_Valid = 1'b1; Sel = OP_XOR; A = 8'h0F; B = 8'hF0;
        exp_q.push_back(model(OP_XOR, 'h0F, 'hF0));
        @(negedge CLK);
        pop_expected(e);
        vectors++; if (Out_Valid !== 1'b1 || In_Ready !== 1'b0) begin miscompares++; $display("FAIL b2b_c1: valid=%b ready=%b expected 1/0", Out_Valid, In_Ready); end
        vectors++; if (Out !== e) begin miscompares++; $display("FAIL b2b_out1: got %h expected %h", Out, e); end
        A = 8'h01; B = 8'h02;
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin miscompares++; $display("FAIL b2b_c2: valid=%b ready=%b expected 0/1", Out_Valid, In_Ready); end
        exp_q.push_back(model(OP_XOR, 1, 2));
        @(negedge CLK);
        In_Valid = 1'b0;
        pop_expected(e);
        vectors++; if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL b2b_c3: valid=%b expected 1", Out_Valid); end
        vectors++; if (Out !== e) begin miscompares++; $display("FAIL b2b_out2: got %h expected %h", Out, e); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_mul();
        logic [15:0] e;
        int          cyc;
        Out_Ready = 1'b1;
        issue(OP_ADD, 8'd255, 8'd1);
        wait_valid(5, cyc);
        pop_expected(e);
        vectors++; if (Out !== e) begin miscompares++; $display("FAIL pre_reset_out: got %h expected %h", Out, e); end
        issue(OP_MUL, 8'd200, 8'd3);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_low: got %b expected 0", In_Ready); end
        @(negedge CLK);
        vectors++; if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL rst_mul_valid: got %b expected 0", Out_Valid); end
        vectors++; if (Out !== 16'h0000) begin miscompares++; $display("FAIL rst_mul_out: got %h expected 0000", Out); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL rst_mul_zero: got %b expected 0", Zero); end
        RST = 1'b1;
        #1;
        vectors++; if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_high: got %b expected 1", In_Ready); end
        issue(OP_ADD, 8'd1, 8'd1);
        wait_valid(12, cyc);
        pop_expected(e);
        vectors++; if (cyc != 1) begin miscompares++; $display("FAIL rst_add_latency: got %0d expected 1", cyc); end
        vectors++; if (Out !== e || Out !== 16'h0002) begin miscompares++; $display("FAIL rst_add_out: got %h expected %h", Out, e); end
    endtask

    task automatic test_sweep();
        logic [15:0] e;
        int          cyc;
        Out_Ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            for (int op = 0; op < 8; op++) begin
                issue(3'(op), 8'(i), 8'(20 - i));
                wait_valid(12, cyc);
                pop_expected(e);
                vectors++;
                if (cyc != ((op == 5) ? 9 : 1) || Out !== e || Zero !== (e == 16'h0000)) begin
                    miscompares++;
                    $display("FAIL sweep op=%0d a=%0d b=%0d: Out=%h Zero=%b cyc=%0d expected %h", op, i, 20 - i, Out, Zero, cyc, e);
                    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                    $fatal(1, "sweep stopped");
                end
                if (i == 7 && op == 7) begin
                    vectors++;
                    if (Out !== 16'h00E0) begin
                        miscompares++;
                        $display("FAIL sweep_shl: got %h expected 00e0", Out);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
